// File: rtl/replay_buf_pkg.sv
// Shared types and helpers for the replay buffer controller.
`default_nettype none

package replay_buf_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Distance from b forward to a on a pw-bit wrapping pointer ring.
    function automatic int unsigned ptr_diff(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned pw);
        return (a - b) & ((32'd1 << pw) - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/replay_buf_ctrl.sv
// Replay buffer sequencer: owns the ram ports, sends words, retires them on cumulative
// ack and rewinds to the oldest unacked entry on nak. Optional macro: REPLAY_STATS_EN.
`default_nettype none

module replay_buf_ctrl
    import replay_buf_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          ack_valid,
    input  logic [AW:0]   ack_seq,
    input  logic          nak,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_din,
    output logic          ram_oe,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   count,
`ifdef REPLAY_STATS_EN
    output logic [15:0]   replay_cnt,
`endif
    output logic          ack_err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(2**AW);

    state_e        state_q;
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   snd_ptr_q;
    logic [AW:0]   ack_ptr_q;
    logic [AW:0]   ack_ptr_d;
    logic          pend_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          ack_err_q;
    logic          init_q;

    logic          w_full;
    logic          w_wr;
    logic          w_ack_ok;
    logic          w_rewind;
    logic [AW:0]   w_ack_dist;
    logic [AW:0]   w_snd_dist;

    assign count     = wr_ptr_q - ack_ptr_q;
    assign w_full    = (count == DEPTH_C);
    // init_q keeps the producer stalled for the first cycle after reset release.
    assign in_ready  = init_q & ~w_full & (state_q != RD);
    assign w_wr      = in_valid & in_ready;

    assign ram_we    = w_wr;
    assign ram_waddr = wr_ptr_q[AW-1:0];
    assign ram_din   = in_data;
    assign ram_oe    = (state_q == RD);
    assign ram_raddr = snd_ptr_q[AW-1:0];

    assign w_ack_dist = (AW+1)'(ptr_diff(32'(ack_seq), 32'(ack_ptr_q), 32'(AW + 1)));
    assign w_snd_dist = (AW+1)'(ptr_diff(32'(snd_ptr_q), 32'(ack_ptr_q), 32'(AW + 1)));
    assign w_ack_ok   = ack_valid & (w_ack_dist <= w_snd_dist);
    assign ack_ptr_d  = w_ack_ok ? ack_seq : ack_ptr_q;
    assign w_rewind   = (state_q == IDLE) & pend_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ack_err   = ack_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            snd_ptr_q   <= '0;
            ack_ptr_q   <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ack_err_q   <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            init_q    <= 1'b1;
            ack_ptr_q <= ack_ptr_d;
            ack_err_q <= ack_valid & ~w_ack_ok;
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (nak) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    // Rewind to the freshest ack pointer; a nak arriving now is absorbed.
                    if (pend_q) begin
                        snd_ptr_q <= ack_ptr_d;
                        pend_q    <= 1'b0;
                    end else if (snd_ptr_q != wr_ptr_q) begin
                        state_q <= RD;
                    end
                end
                RD: begin
                    out_data_q  <= ram_dout;
                    out_valid_q <= 1'b1;
                    snd_ptr_q   <= snd_ptr_q + 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pend_q) begin
                            state_q <= IDLE;
                        end else if (snd_ptr_q != wr_ptr_q) begin
                            state_q <= RD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef REPLAY_STATS_EN
    logic [15:0] replay_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            replay_cnt_q <= '0;
        end else if (w_rewind && (replay_cnt_q != 16'hFFFF)) begin
            replay_cnt_q <= replay_cnt_q + 16'd1;
        end
    end

    assign replay_cnt = replay_cnt_q;
`else
    logic w_unused;
    assign w_unused = w_rewind;
`endif

endmodule

`default_nettype wire

// File: tb/tb_replay_buf_ctrl.sv
// Self-checking bench for replay_buf_ctrl with an 8x16 synchronous-read ram model.
`default_nettype none

module tb_replay_buf_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          ack_valid = 1'b0;
    logic [AW:0]   ack_seq = '0;
    logic          nak = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;
    logic          ram_oe;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   count;
    logic          ack_err;

    always #5 clk = ~clk;

    replay_buf_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ack_valid(ack_valid), .ack_seq(ack_seq), .nak(nak),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_oe(ram_oe), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
        .count(count), .ack_err(ack_err)
    );

    // Storage array: registered read address, output only driven when reading.
    logic [DW-1:0] mem [0:7];
    logic [AW-1:0] raddr_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        raddr_q <= ram_raddr;
    end
    assign ram_dout = (!ram_we && ram_oe) ? mem[raddr_q] : 16'hDEAD;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: words indexed by sequence number, pointers as plain counters.
    logic [DW-1:0] m_data [0:15];
    logic [3:0]    m_wr = '0, m_ack = '0, m_snd = '0, m_hi;
    logic          m_pend = 1'b0, exp_err = 1'b0, err_next;
    logic [DW-1:0] rx_q [$];
    int            rx_cyc [$];
    int            cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_ack_err", ack_err, 0);
            m_wr = '0; m_ack = '0; m_snd = '0; m_pend = 1'b0; exp_err = 1'b0;
        end else begin
            chk("count", count, 32'(4'(m_wr - m_ack)));
            chk("count_le8", (4'(m_wr - m_ack) <= 4'd8), 1);
            chk("ack_err", ack_err, exp_err);
            if (4'(m_wr - m_ack) == 4'd8) chk("full_in_ready", in_ready, 0);
            chk("ram_we", ram_we, in_valid && in_ready);
            chk("we_in_rd", ram_we && ram_oe, 0);
            if (ram_we) begin
                chk("ram_waddr", ram_waddr, 32'(m_wr[2:0]));
                chk("ram_din", ram_din, in_data);
                m_data[m_wr] = in_data;
                m_wr = m_wr + 4'd1;
            end
            // Words sent so far include the one currently presented.
            m_hi = m_snd + (out_valid ? 4'd1 : 4'd0);
            err_next = 1'b0;
            if (ack_valid) begin
                if (4'(ack_seq - m_ack) <= 4'(m_hi - m_ack)) m_ack = ack_seq;
                else err_next = 1'b1;
            end
            if (nak) m_pend = 1'b1;
            if (out_valid && out_ready) begin
                chk("out_data", out_data, m_data[m_snd]);
                rx_q.push_back(out_data);
                rx_cyc.push_back(cyc);
                m_snd = m_snd + 4'd1;
                if (m_pend) begin
                    m_snd  = m_ack;
                    m_pend = 1'b0;
                end
            end
            exp_err = err_next;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_wait", n < 50, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk("valid_wait", out_valid, 1);
    endtask

    task automatic take();
        wait_valid();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 200) begin
            step();
            k++;
        end
        chk("rx_wait", rx_q.size() >= n, 1);
    endtask

    task automatic do_ack(input logic [AW:0] s);
        ack_valid = 1'b1;
        ack_seq   = s;
        step();
        ack_valid = 1'b0;
    endtask

    logic [DW-1:0] exp5 [0:5];

    initial begin
        exp5[0] = 16'h0100; exp5[1] = 16'h0101; exp5[2] = 16'h0102;
        exp5[3] = 16'h0101; exp5[4] = 16'h0102; exp5[5] = 16'h0103;

        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_count", count, 0);

        // Fill with no consumer: eight words fit, the ninth is refused.
        for (int i = 0; i < 8; i++) push(16'(10 * (i + 1)));
        step();
        chk("fill_count", count, 8);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_hold_valid", out_valid, 1);
        chk("fill_hold_data", out_data, 16'h000A);
        in_valid = 1'b1;
        in_data  = 16'h0999;
        repeat (4) step();
        in_valid = 1'b0;
        chk("ninth_count", count, 8);

        // Reset while a word is held.
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_in_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_release_ready", in_ready, 1);
        chk("midrst_release_valid", out_valid, 0);

        // Send three words with the consumer always ready.
        out_ready = 1'b1;
        push(16'h000A);
        push(16'h0014);
        push(16'h001E);
        wait_rx(3);
        chk("send0", rx_q[0], 16'h000A);
        chk("send1", rx_q[1], 16'h0014);
        chk("send2", rx_q[2], 16'h001E);
        chk("rate01", rx_cyc[1] - rx_cyc[0], 2);
        chk("rate12", rx_cyc[2] - rx_cyc[1], 2);
        out_ready = 1'b0;
        repeat (2) step();

        // Cumulative ack, then an out-of-range ack.
        do_ack(4'd2);
        chk("ack_count", count, 1);
        chk("ack_ok_err", ack_err, 0);
        do_ack(4'd7);
        chk("bad_ack_err", ack_err, 1);
        step();
        chk("bad_ack_pulse", ack_err, 0);
        chk("bad_ack_count", count, 1);
        do_ack(4'd3);
        chk("ack_all_count", count, 0);

        // Replay: nak while the third word is held.
        rx_q.delete();
        rx_cyc.delete();
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i));
        take();
        take();
        wait_valid();
        do_ack(4'd4);
        nak = 1'b1;
        step();
        nak = 1'b0;
        repeat (2) step();
        chk("nak_keeps_valid", out_valid, 1);
        chk("nak_keeps_data", out_data, 16'h0102);
        out_ready = 1'b1;
        wait_rx(6);
        for (int i = 0; i < 6; i++) chk("replay_order", rx_q[i], exp5[i]);
        repeat (4) step();
        do_ack(4'd7);
        chk("replay_acked", count, 0);

        // Stream twenty words with prompt acks across the pointer wrap.
        rx_q.delete();
        rx_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            push(16'h0200 + 16'(i));
            wait_rx(i + 1);
            do_ack(4'(7 + i + 1));
        end
        for (int i = 0; i < 20; i++) chk("wrap_order", rx_q[i], 16'h0200 + 16'(i));
        step();
        chk("wrap_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
